pipeline_hold_ctrl: RTL and testbench

Central stall/flush controller that generates the per-register hold and flush controls consumed by the pipeline's hold-capable flip-flop registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Arbitrates stall and flush requests from ID (load-use, branch), EX (multi-cycle divide) and MEM (memory wait, exception).
- Owns the divide-latency FSM and a stall-cycle performance counter.

---
 rtl/pipeline_hold_ctrl_pkg.sv | 35 +++
 rtl/pipeline_hold_ctrl_if.sv | 26 ++
 rtl/pipeline_hold_ctrl_div_latency_fsm.sv | 67 ++++++
 rtl/pipeline_hold_ctrl.sv | 78 +++++++
 tb/tb_pipeline_hold_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hold_ctrl_pkg.sv
// Shared constants for the pipeline hold/flush controller: register indices,
// divide FSM encodings and the hold/flush vector driven for each request type.
package pipeline_hold_ctrl_pkg;

    localparam int NUM_PIPE_REGS = 5;

    localparam int REG_PC    = 0;
    localparam int REG_IFID  = 1;
    localparam int REG_IDEX  = 2;
    localparam int REG_EXMEM = 3;
    localparam int REG_MEMWB = 4;

    typedef logic [NUM_PIPE_REGS-1:0] regvec_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        regvec_t hold;
        regvec_t flush;
    } hold_flush_t;

    // Bit i of each vector addresses pipeline register i (PC is bit 0).
    localparam hold_flush_t HF_RESET   = '{hold: 5'b00000, flush: 5'b11111};
    localparam hold_flush_t HF_EXC     = '{hold: 5'b00000, flush: 5'b11110};
    localparam hold_flush_t HF_MEMWAIT = '{hold: 5'b01111, flush: 5'b10000};
    localparam hold_flush_t HF_DIV     = '{hold: 5'b00111, flush: 5'b01000};
    localparam hold_flush_t HF_LOADUSE = '{hold: 5'b00011, flush: 5'b00100};
    localparam hold_flush_t HF_BRANCH  = '{hold: 5'b00000, flush: 5'b00010};
    localparam hold_flush_t HF_NONE    = '{hold: 5'b00000, flush: 5'b00000};

endpackage

// File: rtl/pipeline_hold_ctrl_if.sv
// Request/response bundle between the pipeline stages (master) and the
// hold/flush controller (slave).
interface pipeline_hold_ctrl_if;
    import pipeline_hold_ctrl_pkg::*;

    logic        load_use;
    logic        branch_taken;
    logic        div_start;
    logic        mem_wait;
    logic        exc_flush;
    regvec_t     hold;
    regvec_t     flush;
    logic        div_ready;
    logic [31:0] stall_cycles;

    modport master (
        output load_use, branch_taken, div_start, mem_wait, exc_flush,
        input  hold, flush, div_ready, stall_cycles
    );

    modport slave (
        input  load_use, branch_taken, div_start, mem_wait, exc_flush,
        output hold, flush, div_ready, stall_cycles
    );

endinterface

// File: rtl/pipeline_hold_ctrl_div_latency_fsm.sv
// Multi-cycle divide tracker: stalls the front of the pipe for DIV_CYCLES
// cycles, then presents div_ready until MEM lets the result move on.
module div_latency_fsm
    import pipeline_hold_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic div_start,
    input  logic mem_wait,
    input  logic exc_flush,
    output logic div_stall,
    output logic div_ready
);

    // The IDLE cycle that sees div_start is already a stall cycle, so BUSY
    // only needs to cover the remaining DIV_CYCLES-1 cycles.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_CYCLES - 2);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst || exc_flush) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_start) begin
                        state_d = DIV_BUSY;
                        cnt_d   = CNT_START;
                    end
                end
                DIV_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = DIV_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DIV_DONE: begin
                    if (!mem_wait) begin
                        state_d = DIV_IDLE;
                    end
                end
                default: begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    assign div_stall = ((state_q == DIV_IDLE) && div_start) || (state_q == DIV_BUSY);
    assign div_ready = (state_q == DIV_DONE) && !exc_flush && !rst;

endmodule

// File: rtl/pipeline_hold_ctrl.sv
// Central stall/flush arbiter: turns stage hazard requests into per-register
// hold/flush controls and counts cycles in which anything is held.
module pipeline_hold_ctrl
    import pipeline_hold_ctrl_pkg::*;
#(
    parameter int          NUM_REGS      = NUM_PIPE_REGS,
    parameter int          DIV_CYCLES    = 32,
    parameter int          CNT_W         = $clog2(DIV_CYCLES),
    parameter logic [31:0] STALL_RST_VAL = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hold_ctrl_if.slave  bus
);

    logic                div_stall;
    logic                div_ready;
    logic [NUM_REGS-1:0] hold_c;
    logic [NUM_REGS-1:0] flush_c;
    hold_flush_t         sel;
    logic [31:0]         stall_cycles_q, stall_cycles_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    div_latency_fsm #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_fsm (
        .clk       (clk),
        .rst       (rst),
        .div_start (bus.div_start),
        .mem_wait  (bus.mem_wait),
        .exc_flush (bus.exc_flush),
        .div_stall (div_stall),
        .div_ready (div_ready)
    );

    // A taken branch is dropped under any stall; ID re-presents it afterwards.
    always_comb begin
        sel = HF_NONE;
        if (rst) begin
            sel = HF_RESET;
        end else if (bus.exc_flush) begin
            sel = HF_EXC;
        end else if (bus.mem_wait) begin
            sel = HF_MEMWAIT;
        end else if (div_stall) begin
            sel = HF_DIV;
        end else if (bus.load_use) begin
            sel = HF_LOADUSE;
        end else if (bus.branch_taken) begin
            sel = HF_BRANCH;
        end
        hold_c  = sel.hold;
        flush_c = sel.flush;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (rst) begin
            stall_cycles_d = STALL_RST_VAL;
        end else if (|hold_c) begin
            stall_cycles_d = sat_inc(stall_cycles_q);
        end
    end

    always_ff @(posedge clk) begin
        stall_cycles_q <= stall_cycles_d;
    end

    assign bus.hold         = hold_c;
    assign bus.flush        = flush_c;
    assign bus.div_ready    = div_ready;
    assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Bench for pipeline_hold_ctrl: directed literal scenarios followed by random
// request traffic, all checked every cycle against a cycle-budget model.
module tb_pipeline_hold_ctrl;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hold_ctrl_if bus ();
    pipeline_hold_ctrl_if bus2 ();

    pipeline_hold_ctrl #(.NUM_REGS(5), .DIV_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Counter preloaded near its ceiling so saturation is reachable quickly.
    pipeline_hold_ctrl #(.NUM_REGS(5), .DIV_CYCLES(DC), .STALL_RST_VAL(32'hFFFF_FFFE)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Model: the divide is tracked as "stall cycles still owed" plus a
    // result-pending flag; outputs come straight from the priority list.
    bit              model_on = 1'b0;
    int              m_left   = 0;
    bit              m_done   = 1'b0;
    longint unsigned m_stall  = 0;

    always @(negedge clk) begin
        logic [4:0] eh, ef;
        logic       er, div_req;
        if (model_on) begin
            div_req = (m_left > 0) || (!m_done && bus.div_start);
            if (rst)                   begin eh = 5'b00000; ef = 5'b11111; end
            else if (bus.exc_flush)    begin eh = 5'b00000; ef = 5'b11110; end
            else if (bus.mem_wait)     begin eh = 5'b01111; ef = 5'b10000; end
            else if (div_req)          begin eh = 5'b00111; ef = 5'b01000; end
            else if (bus.load_use)     begin eh = 5'b00011; ef = 5'b00100; end
            else if (bus.branch_taken) begin eh = 5'b00000; ef = 5'b00010; end
            else                       begin eh = 5'b00000; ef = 5'b00000; end
            er = m_done && !rst && !bus.exc_flush;

            chk("model_hold", 32'(bus.hold), 32'(eh));
            chk("model_flush", 32'(bus.flush), 32'(ef));
            chk("model_div_ready", 32'(bus.div_ready), 32'(er));
            chk("model_stall_cycles", bus.stall_cycles, m_stall[31:0]);

            if (rst) begin
                m_left  = 0;
                m_done  = 1'b0;
                m_stall = 0;
            end else begin
                if (eh != 5'b0 && m_stall < 64'hFFFF_FFFF) m_stall++;
                if (bus.exc_flush) begin
                    m_left = 0;
                    m_done = 1'b0;
                end else if (m_done) begin
                    m_done = bus.mem_wait;
                end else if (m_left > 0) begin
                    if (m_left == 1) begin
                        m_left = 0;
                        m_done = 1'b1;
                    end else begin
                        m_left--;
                    end
                end else if (bus.div_start) begin
                    m_left = DC - 1;
                end
            end
        end
    end

    task automatic set_req(input logic lu, input logic br, input logic ds,
                           input logic mw, input logic ex);
        bus.load_use     = lu;
        bus.branch_taken = br;
        bus.div_start    = ds;
        bus.mem_wait     = mw;
        bus.exc_flush    = ex;
    endtask

    initial begin
        rst = 1'b1;
        set_req(0, 0, 0, 0, 0);
        bus2.load_use = 0; bus2.branch_taken = 0; bus2.div_start = 0;
        bus2.mem_wait = 0; bus2.exc_flush = 0;

        // Reset behaviour
        cyc(); model_on = 1'b1; smp();
        chk("rst_hold", 32'(bus.hold), 32'h00);
        chk("rst_flush", 32'(bus.flush), 32'h1F);
        chk("rst_div_ready", 32'(bus.div_ready), 32'h0);
        cyc(); smp();
        chk("rst2_flush", 32'(bus.flush), 32'h1F);
        cyc(); rst = 1'b0; smp();
        chk("post_rst_hold", 32'(bus.hold), 32'h00);
        chk("post_rst_flush", 32'(bus.flush), 32'h00);
        chk("post_rst_stall", bus.stall_cycles, 32'd0);

        // Plain divide
        cyc(); set_req(0, 0, 1, 0, 0); smp();
        chk("div_t0_hold", 32'(bus.hold), 32'h07);
        chk("div_t0_flush", 32'(bus.flush), 32'h08);
        for (int i = 1; i < DC; i++) begin
            cyc(); smp();
            chk("div_busy_hold", 32'(bus.hold), 32'h07);
            chk("div_busy_flush", 32'(bus.flush), 32'h08);
            chk("div_busy_ready", 32'(bus.div_ready), 32'h0);
        end
        cyc(); smp();
        chk("div_done_ready", 32'(bus.div_ready), 32'h1);
        chk("div_done_hold", 32'(bus.hold), 32'h00);
        chk("div_done_stall", bus.stall_cycles, 32'd4);
        cyc(); set_req(0, 0, 0, 0, 0); smp();
        chk("div_idle_ready", 32'(bus.div_ready), 32'h0);

        // Divide overlapped by mem_wait
        cyc(); rst = 1'b1; smp();
        cyc(); rst = 1'b0; set_req(0, 0, 1, 0, 0); smp();
        chk("dmw_t0_hold", 32'(bus.hold), 32'h07);
        for (int t = 1; t <= 6; t++) begin
            cyc(); bus.mem_wait = 1'b1; smp();
            chk("dmw_hold", 32'(bus.hold), 32'h0F);
            chk("dmw_flush", 32'(bus.flush), 32'h10);
            chk("dmw_ready", 32'(bus.div_ready), (t >= DC) ? 32'h1 : 32'h0);
        end
        cyc(); set_req(0, 0, 0, 0, 0); smp();
        chk("dmw_t7_ready", 32'(bus.div_ready), 32'h1);
        chk("dmw_t7_hold", 32'(bus.hold), 32'h00);
        chk("dmw_t7_stall", bus.stall_cycles, 32'd7);
        cyc(); smp();
        chk("dmw_t8_ready", 32'(bus.div_ready), 32'h0);

        // load_use beats branch, then branch alone
        cyc(); set_req(1, 1, 0, 0, 0); smp();
        chk("lu_br_hold", 32'(bus.hold), 32'h03);
        chk("lu_br_flush", 32'(bus.flush), 32'h04);
        cyc(); set_req(0, 1, 0, 0, 0); smp();
        chk("br_hold", 32'(bus.hold), 32'h00);
        chk("br_flush", 32'(bus.flush), 32'h02);

        // Exception cancels a divide held up by mem_wait
        cyc(); set_req(0, 0, 1, 0, 0); smp();
        cyc(); set_req(0, 0, 1, 1, 0); smp();
        chk("exc_t1_hold", 32'(bus.hold), 32'h0F);
        cyc(); set_req(0, 0, 1, 1, 1); smp();
        chk("exc_t2_hold", 32'(bus.hold), 32'h00);
        chk("exc_t2_flush", 32'(bus.flush), 32'h1E);
        chk("exc_t2_ready", 32'(bus.div_ready), 32'h0);
        for (int t = 3; t <= 6; t++) begin
            cyc(); set_req(0, 0, 0, 0, 0); smp();
            chk("exc_after_hold", 32'(bus.hold), 32'h00);
            chk("exc_after_ready", 32'(bus.div_ready), 32'h0);
        end

        // Saturating perf counter
        cyc(); bus2.load_use = 1'b1; smp();
        chk("sat_start", bus2.stall_cycles, 32'hFFFF_FFFE);
        chk("sat_hold", 32'(bus2.hold), 32'h03);
        cyc(); smp();
        chk("sat_1", bus2.stall_cycles, 32'hFFFF_FFFF);
        cyc(); smp();
        chk("sat_2", bus2.stall_cycles, 32'hFFFF_FFFF);
        cyc(); bus2.load_use = 1'b0; smp();
        chk("sat_3", bus2.stall_cycles, 32'hFFFF_FFFF);

        // Random request traffic
        for (int n = 0; n < 4000; n++) begin
            cyc();
            rst              = ($urandom_range(0, 299) == 0);
            bus.exc_flush    = ($urandom_range(0, 39) == 0);
            bus.mem_wait     = ($urandom_range(0, 3) == 0);
            bus.load_use     = ($urandom_range(0, 3) == 0);
            bus.branch_taken = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) bus.div_start = ~bus.div_start;
        end

        cyc();
        smp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
